// File: rtl/line_scheduler.sv
// line_scheduler: feeds nonogram lines (rows, then columns) to a line solver one at a time.
// Keeps a remaining-option count per line and round-robins over the lines that are
// still live (count != 0). It finishes with solved once every line is retired, or with
// stuck once a full round of live lines makes no progress.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, num_rows, num_cols,    begin scheduling a parsed board (accepted only when idle)
//   init_opts                     packed initial option counts, line i at [i*OW +: OW]
//   line_valid/line_ready,        issued line handshake
//   line_idx, line_opts
//   res_valid, res_opts,          solver result for the line in flight
//   res_progress
//   busy, solved, stuck           status; solved/stuck stay set until the next accepted start
module line_scheduler #(
    parameter int unsigned MAX_ROWS        = 11,
    parameter int unsigned MAX_COLS        = 11,
    parameter int unsigned MAX_NUM_OPTIONS = 84,
    localparam int unsigned NL = MAX_ROWS + MAX_COLS,
    localparam int unsigned IW = $clog2(NL),
    localparam int unsigned OW = $clog2(MAX_NUM_OPTIONS + 1),
    localparam int unsigned RW = $clog2(MAX_ROWS + 1),
    localparam int unsigned CW = $clog2(MAX_COLS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [RW-1:0]    num_rows,
    input  logic [CW-1:0]    num_cols,
    input  logic [NL*OW-1:0] init_opts,
    output logic             line_valid,
    input  logic             line_ready,
    output logic [IW-1:0]    line_idx,
    output logic [OW-1:0]    line_opts,
    input  logic             res_valid,
    input  logic [OW-1:0]    res_opts,
    input  logic             res_progress,
    output logic             busy,
    output logic             solved,
    output logic             stuck
);
    localparam int unsigned LW = $clog2(NL + 1);
    localparam int unsigned TW = ((RW > CW) ? RW : CW) + 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SCAN  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [OW-1:0] tbl_q [NL];
    logic [OW-1:0] tbl_d [NL];
    logic [IW-1:0] ptr_q, ptr_d;
    logic [LW-1:0] live_q, live_d;
    logic [LW-1:0] streak_q, streak_d;
    logic [TW-1:0] total_q, total_d;
    logic          valid_q, valid_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [OW-1:0] opts_q, opts_d;
    logic          busy_q, busy_d;
    logic          solved_q, solved_d;
    logic          stuck_q, stuck_d;
    logic [LW-1:0] load_live;

    // Round-robin successor; also wraps at the table end so an oversized total cannot
    // walk the pointer off the table.
    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p, input logic [TW-1:0] tot);
        if ((int'(p) + 1 >= int'(tot)) || (int'(p) == int'(NL) - 1)) begin
            return '0;
        end
        return p + IW'(1);
    endfunction

    always_comb begin
        state_d   = state_q;
        tbl_d     = tbl_q;
        ptr_d     = ptr_q;
        live_d    = live_q;
        streak_d  = streak_q;
        total_d   = total_q;
        valid_d   = valid_q;
        idx_d     = idx_q;
        opts_d    = opts_q;
        solved_d  = solved_q;
        stuck_d   = stuck_q;
        load_live = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    total_d = TW'(num_rows) + TW'(num_cols);
                    for (int i = 0; i < int'(NL); i++) begin
                        if (i < int'(total_d)) begin
                            tbl_d[i] = init_opts[i*OW +: OW];
                        end else begin
                            tbl_d[i] = '0;
                        end
                        if (tbl_d[i] != '0) begin
                            load_live = load_live + LW'(1);
                        end
                    end
                    live_d   = load_live;
                    ptr_d    = '0;
                    streak_d = '0;
                    solved_d = 1'b0;
                    stuck_d  = 1'b0;
                    state_d  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (live_q == '0) begin
                    solved_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (tbl_q[ptr_q] != '0) begin
                    idx_d   = ptr_q;
                    opts_d  = tbl_q[ptr_q];
                    valid_d = 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    ptr_d = next_ptr(ptr_q, total_q);
                end
            end
            ST_ISSUE: begin
                if (line_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (res_valid) begin
                    tbl_d[idx_q] = res_opts;
                    if (res_opts == '0 && tbl_q[idx_q] != '0 && live_q != '0) begin
                        live_d = live_q - LW'(1);
                    end
                    if (res_progress) begin
                        streak_d = '0;
                    end else if (streak_q < LW'(NL)) begin
                        streak_d = streak_q + LW'(1);
                    end
                    ptr_d   = next_ptr(idx_q, total_q);
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (live_q == '0) begin
                    solved_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (streak_q >= live_q) begin
                    // Every live line has been tried since the last progress.
                    stuck_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            for (int i = 0; i < int'(NL); i++) begin
                tbl_q[i] <= '0;
            end
            ptr_q    <= '0;
            live_q   <= '0;
            streak_q <= '0;
            total_q  <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            opts_q   <= '0;
            busy_q   <= 1'b0;
            solved_q <= 1'b0;
            stuck_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tbl_q    <= tbl_d;
            ptr_q    <= ptr_d;
            live_q   <= live_d;
            streak_q <= streak_d;
            total_q  <= total_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            opts_q   <= opts_d;
            busy_q   <= busy_d;
            solved_q <= solved_d;
            stuck_q  <= stuck_d;
        end
    end

    assign line_valid = valid_q;
    assign line_idx   = idx_q;
    assign line_opts  = opts_q;
    assign busy       = busy_q;
    assign solved     = solved_q;
    assign stuck      = stuck_q;

endmodule

// File: tb/tb_line_scheduler.sv
// tb_line_scheduler: drives line_scheduler with directed and random boards and a scripted
// solver. A transaction-level model predicts, from the scheduling rules, when each line is
// issued and which one, and a single compare process checks every output on every cycle.
module tb_line_scheduler;
    localparam int NL = 22;
    localparam int IW = 5;
    localparam int OW = 7;
    localparam int RW = 4;
    localparam int CW = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [RW-1:0]    num_rows = '0;
    logic [CW-1:0]    num_cols = '0;
    logic [NL*OW-1:0] init_opts = '0;
    logic             line_valid;
    logic             line_ready = 1'b0;
    logic [IW-1:0]    line_idx;
    logic [OW-1:0]    line_opts;
    logic             res_valid = 1'b0;
    logic [OW-1:0]    res_opts = '0;
    logic             res_progress = 1'b0;
    logic             busy;
    logic             solved;
    logic             stuck;

    line_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_rows     (num_rows),
        .num_cols     (num_cols),
        .init_opts    (init_opts),
        .line_valid   (line_valid),
        .line_ready   (line_ready),
        .line_idx     (line_idx),
        .line_opts    (line_opts),
        .res_valid    (res_valid),
        .res_opts     (res_opts),
        .res_progress (res_progress),
        .busy         (busy),
        .solved       (solved),
        .stuck        (stuck)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    // Expected outputs, updated just after each active edge.
    int exp_valid = 0, exp_idx = 0, exp_opts = 0, exp_busy = 0, exp_solved = 0, exp_stuck = 0;

    int tbl [NL];
    int issue_log[$];
    int opts_log[$];

    task automatic check(input string nm, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("line_valid", int'(line_valid), exp_valid);
            check("line_idx",   int'(line_idx),   exp_idx);
            check("line_opts",  int'(line_opts),  exp_opts);
            check("busy",       int'(busy),       exp_busy);
            check("solved",     int'(solved),     exp_solved);
            check("stuck",      int'(stuck),      exp_stuck);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int count_live();
        int c = 0;
        for (int i = 0; i < NL; i++) if (tbl[i] != 0) c++;
        return c;
    endfunction

    // mode 0: retire with progress; 1: echo count, no progress;
    // 2: random shrink; 3: decrement with progress.
    task automatic policy(input int mode, input int cur, output int res, output int prg);
        case (mode)
            0: begin res = 0; prg = 1; end
            1: begin res = cur; prg = 0; end
            2: begin res = $urandom_range(cur, 0); prg = (res < cur) ? 1 : 0; end
            default: begin res = cur - 1; prg = 1; end
        endcase
    endtask

    task automatic run_puzzle(input int nr, input int nc, input int vals[NL], input int mode,
                              input int hold, input bit rst_in_wait);
        int total, live, j, d, w, res, prg, streak, ptr;
        bit done = 0;
        issue_log.delete();
        opts_log.delete();
        num_rows = RW'(nr);
        num_cols = CW'(nc);
        for (int i = 0; i < NL; i++) init_opts[i*OW +: OW] = OW'(vals[i]);
        start = 1'b1;
        tick();
        start = 1'b0;
        total = nr + nc;
        for (int i = 0; i < NL; i++) tbl[i] = (i < total) ? vals[i] : 0;
        ptr = 0;
        streak = 0;
        exp_solved = 0;
        exp_stuck = 0;
        exp_busy = 1;
        for (int it = 0; it < 400 && !done; it++) begin
            live = count_live();
            if (live == 0) begin
                tick();
                exp_solved = 1;
                exp_busy = 0;
                done = 1;
                break;
            end
            // Next live line in round-robin order from ptr; each skipped line costs a cycle.
            d = 0;
            j = ptr;
            while (tbl[j] == 0) begin
                j = (j + 1) % total;
                d++;
            end
            repeat (d) tick();
            tick();
            exp_valid = 1;
            exp_idx = j;
            exp_opts = tbl[j];
            issue_log.push_back(int'(line_idx));
            opts_log.push_back(int'(line_opts));
            w = (hold >= 0) ? hold : int'($urandom_range(3, 0));
            for (int k = 0; k < w; k++) begin
                if ($urandom_range(3, 0) == 0) begin
                    res_valid = 1'b1;
                    res_opts = OW'($urandom_range(84, 0));
                end
                if ($urandom_range(3, 0) == 0) begin
                    start = 1'b1;
                    num_rows = RW'($urandom_range(11, 0));
                end
                tick();
                res_valid = 1'b0;
                start = 1'b0;
            end
            line_ready = 1'b1;
            tick();
            line_ready = 1'b0;
            exp_valid = 0;
            if (rst_in_wait) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                exp_idx = 0; exp_opts = 0; exp_busy = 0; exp_solved = 0; exp_stuck = 0;
                done = 1;
                break;
            end
            repeat ($urandom_range(2, 0)) tick();
            policy(mode, tbl[j], res, prg);
            res_valid = 1'b1;
            res_opts = OW'(res);
            res_progress = prg[0];
            tick();
            res_valid = 1'b0;
            tbl[j] = res;
            streak = (prg != 0) ? 0 : ((streak < NL) ? streak + 1 : NL);
            ptr = (j + 1) % total;
            live = count_live();
            tick();
            if (live == 0) begin
                exp_solved = 1; exp_busy = 0; done = 1;
            end else if (streak >= live) begin
                exp_stuck = 1; exp_busy = 0; done = 1;
            end
        end
        if (!done) begin
            n_vec++;
            n_fail++;
            $display("FAIL budget: puzzle did not finish, issues=%0d", issue_log.size());
        end
        tick();
        tick();
    endtask

    initial begin
        int v[NL];
        repeat (3) tick();
        rst = 1'b0;
        chk_en = 1;
        tick();

        // T1: 2x2 all ones, retire each line.
        v = '{default: 0};
        for (int i = 0; i < 4; i++) v[i] = 1;
        run_puzzle(2, 2, v, 0, -1, 0);
        check("t1_issues", issue_log.size(), 4);
        for (int i = 0; i < 4 && i < issue_log.size(); i++) check("t1_order", issue_log[i], i);
        check("t1_solved", int'(solved), 1);
        check("t1_stuck", int'(stuck), 0);

        // T2: zeros are skipped.
        v = '{default: 0};
        v[1] = 3; v[3] = 2;
        run_puzzle(2, 2, v, 0, -1, 0);
        check("t2_issues", issue_log.size(), 2);
        if (issue_log.size() == 2) begin
            check("t2_idx0", issue_log[0], 1);
            check("t2_opt0", opts_log[0], 3);
            check("t2_idx1", issue_log[1], 3);
            check("t2_opt1", opts_log[1], 2);
        end

        // T3: no progress -> stuck after one round.
        run_puzzle(2, 2, v, 1, -1, 0);
        check("t3_issues", issue_log.size(), 2);
        check("t3_stuck", int'(stuck), 1);
        check("t3_busy", int'(busy), 0);

        // T4: ready held low for 5 cycles, single transfer.
        v = '{default: 0};
        v[2] = 5;
        run_puzzle(2, 2, v, 0, 5, 0);
        check("t4_issues", issue_log.size(), 1);

        // T5: reset while waiting for a result, then a fresh board.
        v = '{default: 0};
        v[1] = 4; v[2] = 4;
        run_puzzle(2, 2, v, 0, -1, 1);
        v = '{default: 0};
        v[0] = 2; v[3] = 1;
        run_puzzle(2, 2, v, 0, -1, 0);
        if (issue_log.size() > 0) check("t5_first_idx", issue_log[0], 0);

        // T6: 11x11 with wrap from line 21 back to the lowest live line.
        v = '{default: 0};
        v[2] = 2; v[21] = 2;
        run_puzzle(11, 11, v, 3, -1, 0);
        check("t6_issues", issue_log.size(), 4);
        if (issue_log.size() == 4) begin
            check("t6_idx1", issue_log[1], 21);
            check("t6_idx2", issue_log[2], 2);
            check("t6_opt2", opts_log[2], 1);
        end

        // Degenerate empty board.
        v = '{default: 0};
        run_puzzle(0, 0, v, 0, -1, 0);
        check("empty_issues", issue_log.size(), 0);

        // Random boards.
        for (int p = 0; p < 10; p++) begin
            int nr, nc;
            nr = $urandom_range(11, 0);
            nc = $urandom_range(11, 0);
            for (int i = 0; i < NL; i++)
                v[i] = ($urandom_range(9, 0) < 3) ? 0 : int'($urandom_range(6, 1));
            run_puzzle(nr, nc, v, $urandom_range(2, 0), -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
